// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 1-cycle registered output stage.
// SKID selects a 2-entry skid buffer (flopped in_ready) or a single output register.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } res_t;

  fmt_e            fmt_s;
  logic            pc_rel_s;
  logic            illegal_s;
  logic [XLEN-1:0] imm_s;
  res_t            dec_s;
  logic            in_fire_s;
  logic            out_fire_s;

  // Opcode classification; compressed (non-32-bit) encodings decode as NONE
  always_comb begin
    fmt_s     = FMT_NONE;
    pc_rel_s  = 1'b0;
    illegal_s = (in_inst[1:0] != 2'b11);
    if (illegal_s) begin
      fmt_s = FMT_NONE;
    end else begin
      case (in_inst[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: fmt_s = FMT_I;
        7'b0011011: fmt_s = (XLEN == 64) ? FMT_I : FMT_NONE;
        7'b0100011: fmt_s = FMT_S;
        7'b1100011: begin
          fmt_s    = FMT_B;
          pc_rel_s = 1'b1;
        end
        7'b0110111: fmt_s = FMT_U;
        7'b0010111: begin
          fmt_s    = FMT_U;
          pc_rel_s = 1'b1;
        end
        7'b1101111: begin
          fmt_s    = FMT_J;
          pc_rel_s = 1'b1;
        end
        7'b1110011: fmt_s = in_inst[14] ? FMT_Z : FMT_NONE;
        default:    fmt_s = FMT_NONE;
      endcase
    end
  end

  // Immediate extraction and sign/zero extension
  always_comb begin
    imm_s = '0;
    case (fmt_s)
      FMT_I:   imm_s = XLEN'($signed(in_inst[31:20]));
      FMT_S:   imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B:   imm_s = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                      in_inst[11:8], 1'b0}));
      FMT_J:   imm_s = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                      in_inst[30:21], 1'b0}));
      FMT_U:   imm_s = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_Z:   imm_s = XLEN'(in_inst[19:15]);
      default: imm_s = '0;
    endcase
  end

  // Full result formed before the register so outputs are pure flops
  always_comb begin
    dec_s.imm     = imm_s;
    dec_s.fmt     = fmt_s;
    dec_s.target  = pc_rel_s ? (in_pc + imm_s) : '0;
    dec_s.illegal = illegal_s;
  end

  if (SKID != 0) begin : g_skid
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    res_t main_q, main_d;
    res_t skid_q, skid_d;

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = main_valid_q & out_ready;

    // Main/skid occupancy update; skid only fills while main is stalled
    always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (out_fire_s) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_fire_s) begin
          main_d = dec_s;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire_s) begin
        if (main_valid_q) begin
          skid_valid_d = 1'b1;
          skid_d       = dec_s;
        end else begin
          main_valid_d = 1'b1;
          main_d       = dec_s;
        end
      end else begin
        main_valid_d = main_valid_q;
      end
      in_ready_d = !skid_valid_d;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
        main_q       <= '0;
        skid_q       <= '0;
      end else begin
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
        in_ready_q   <= in_ready_d;
        main_q       <= main_d;
        skid_q       <= skid_d;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign {out_imm, out_fmt, out_target, out_illegal} = main_q;
  end else begin : g_single
    logic valid_q, valid_d;
    res_t data_q, data_d;

    assign in_ready   = out_ready | !valid_q;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = valid_q & out_ready;

    // Single-entry pipeline register update
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_fire_s) begin
        valid_d = 1'b1;
        data_d  = dec_s;
      end else if (out_fire_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid = valid_q;
    assign {out_imm, out_fmt, out_target, out_illegal} = data_q;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances share stimulus; each is
// scored against a queue model of the decoded stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [63:0] in_pc = 64'h0;

  always #5 clk = ~clk;

  logic        r32, v32, ill32, r64, v64, ill64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt32, fmt64;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .SKID(0)) u_d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_illegal(ill64));

  logic        o_valid [2];
  logic        o_rdy   [2];
  logic        o_ill   [2];
  logic [63:0] o_imm   [2];
  logic [63:0] o_tgt   [2];
  logic [2:0]  o_fmt   [2];

  assign o_valid[0] = v32;   assign o_valid[1] = v64;
  assign o_rdy[0]   = r32;   assign o_rdy[1]   = r64;
  assign o_ill[0]   = ill32; assign o_ill[1]   = ill64;
  assign o_imm[0]   = {32'h0, imm32}; assign o_imm[1] = imm64;
  assign o_tgt[0]   = {32'h0, tgt32}; assign o_tgt[1] = tgt64;
  assign o_fmt[0]   = fmt32; assign o_fmt[1]   = fmt64;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_total = 0;
  int   n_bad = 0;

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
  logic [31:0] bp [4] = '{32'h00412083, 32'h00812103, 32'hFF012183, 32'h7FF12203};

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: immediate as a signed integer value, then truncated to xlen
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    logic [63:0] mask;
    bit     rel;
    int     f;
    mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.ill = (inst[1:0] != 2'b11);
    v = 0; f = 0; rel = 1'b0;
    if (!e.ill) begin
      case (inst[6:0])
        7'h03, 7'h13, 7'h67: begin f = 1; v = $signed(inst[31:20]); end
        7'h1B: if (xlen == 64) begin f = 1; v = $signed(inst[31:20]); end
        7'h23: begin f = 2; v = $signed({inst[31:25], inst[11:7]}); end
        7'h63: begin f = 3; rel = 1'b1;
                 v = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); end
        7'h37: begin f = 4; v = $signed(inst[31:12]) * 4096; end
        7'h17: begin f = 4; rel = 1'b1; v = $signed(inst[31:12]) * 4096; end
        7'h6F: begin f = 5; rel = 1'b1;
                 v = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}); end
        7'h73: if (inst[14]) begin f = 6; v = longint'(inst[19:15]); end
        default: f = 0;
      endcase
    end
    e.imm = 64'(v) & mask;
    e.tgt = rel ? ((pc + 64'(v)) & mask) : 64'h0;
    e.fmt = 3'(f);
    return e;
  endfunction

  // One clock of stimulus: drive, check both DUTs against their models, advance models
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic ordy, input logic fl, output bit acc0);
    exp_t h;
    int   sz;
    bit   rdy;
    bit   acc [2];
    bit   drn [2];
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz  = (d == 0) ? q0.size() : q1.size();
      rdy = (d == 0) ? (sz < 2) : (ordy || sz == 0);
      chk_eq($sformatf("d%0d_in_ready", d), 64'(o_rdy[d]), 64'(rdy));
      chk_eq($sformatf("d%0d_out_valid", d), 64'(o_valid[d]), 64'(sz > 0));
      if (sz > 0) begin
        h = (d == 0) ? q0[0] : q1[0];
        chk_eq($sformatf("d%0d_imm", d), o_imm[d], h.imm);
        chk_eq($sformatf("d%0d_fmt", d), 64'(o_fmt[d]), 64'(h.fmt));
        chk_eq($sformatf("d%0d_target", d), o_tgt[d], h.tgt);
        chk_eq($sformatf("d%0d_illegal", d), 64'(o_ill[d]), 64'(h.ill));
      end
      acc[d] = v && rdy;
      drn[d] = (sz > 0) && ordy;
    end
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (drn[0]) void'(q0.pop_front());
      if (drn[1]) void'(q1.pop_front());
      if (acc[0]) q0.push_back(ref_dec(inst, pc, 32));
      if (acc[1]) q1.push_back(ref_dec(inst, pc, 64));
    end
    acc0 = acc[0] && !fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("rst%0d_valid", d), 64'(o_valid[d]), 64'h0);
      chk_eq($sformatf("rst%0d_rdy", d), 64'(o_rdy[d]), 64'h1);
      chk_eq($sformatf("rst%0d_imm", d), o_imm[d], 64'h0);
      chk_eq($sformatf("rst%0d_fmt", d), 64'(o_fmt[d]), 64'h0);
      chk_eq($sformatf("rst%0d_tgt", d), o_tgt[d], 64'h0);
      chk_eq($sformatf("rst%0d_ill", d), 64'(o_ill[d]), 64'h0);
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          a;
    int          idx;
    logic [31:0] ri;
    do_reset();

    step(1'b1, 32'hFFC12083, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("lw_valid", 64'(o_valid[0]), 64'h1);
    chk_eq("lw_imm", o_imm[0], 64'h0000_0000_FFFF_FFFC);
    chk_eq("lw_fmt", 64'(o_fmt[0]), 64'h1);
    chk_eq("lw_tgt", o_tgt[0], 64'h0);
    chk_eq("lw_ill", 64'(o_ill[0]), 64'h0);
    chk_eq("lw64_imm", o_imm[1], 64'hFFFF_FFFF_FFFF_FFFC);

    step(1'b1, 32'hFE000CE3, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("beq_imm", o_imm[0], 64'h0000_0000_FFFF_FFF8);
    chk_eq("beq_fmt", 64'(o_fmt[0]), 64'h3);
    chk_eq("beq_tgt", o_tgt[0], 64'h0000_0000_0000_00F8);

    step(1'b1, 32'h123452B7, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("lui_imm", o_imm[0], 64'h0000_0000_1234_5000);
    chk_eq("lui_fmt", 64'(o_fmt[0]), 64'h4);
    chk_eq("lui_tgt", o_tgt[0], 64'h0);

    step(1'b1, 32'h340FD073, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("csr_imm", o_imm[0], 64'h0000_0000_0000_001F);
    chk_eq("csr_fmt", 64'(o_fmt[0]), 64'h6);

    step(1'b1, 32'h0010809B, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("addiw32_fmt", 64'(o_fmt[0]), 64'h0);
    chk_eq("addiw64_fmt", 64'(o_fmt[1]), 64'h1);

    step(1'b1, 32'hFFC12080, 64'h100, 1'b1, 1'b0, a);
    post_edge();
    chk_eq("rvc_ill", 64'(o_ill[0]), 64'h1);
    chk_eq("rvc_fmt", 64'(o_fmt[0]), 64'h0);
    chk_eq("rvc_imm", o_imm[0], 64'h0);

    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Backpressure: four beats offered back-to-back, consumer stalled 3 cycles
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || q0.size() != 0); c++) begin
      step(idx < 4, bp[(idx < 4) ? idx : 0], 64'h200, c >= 3, 1'b0, a);
      if (c == 2) chk_eq("bp_rdy_drop", 64'(o_rdy[0]), 64'h0);
      if (a) idx++;
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Flush with two entries held and a beat offered in the same cycle
    step(1'b1, bp[0], 64'h300, 1'b0, 1'b0, a);
    step(1'b1, bp[1], 64'h300, 1'b0, 1'b0, a);
    step(1'b1, bp[2], 64'h300, 1'b0, 1'b1, a);
    post_edge();
    chk_eq("fl_valid", 64'(o_valid[0]), 64'h0);
    chk_eq("fl_rdy", 64'(o_rdy[0]), 64'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Reset in the middle of a stall
    step(1'b1, bp[0], 64'h400, 1'b0, 1'b0, a);
    step(1'b1, bp[1], 64'h400, 1'b0, 1'b0, a);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Randomized traffic with occasional flush and one reset
    for (int c = 0; c < 600; c++) begin
      ri = $urandom;
      if ($urandom_range(7) != 0) ri[6:0] = ops[$urandom_range(10)];
      if (c == 300) do_reset();
      step($urandom_range(3) != 0, ri, {$urandom, $urandom},
           $urandom_range(2) != 0, $urandom_range(24) == 0, a);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
